// File: rtl/ahb_slave_if.sv
// AHB slave front end: each accepted NONSEQ/SEQ transfer becomes one backend request on other_*.
// Optional backend wait limit is compiled in when AHB_SLAVE_TIMEOUT_EN is defined.
module ahb_slave_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rstn_in,
  input  logic                        ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic                        ahb_write_in,
  input  logic [2:0]                  ahb_size_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic [3:0]                  ahb_prot_in,
  input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
  input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
  input  logic                        ahb_ready_in,
  output logic                        ahb_readyout_out,
  output logic                        ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
  output logic                        other_valid_out,
  output logic                        other_write_out,
  output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
  output logic [2:0]                  other_size_out,
  output logic [3:0]                  other_prot_out,
  output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
  input  logic                        other_ready_in,
  input  logic                        other_error_in,
  input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_DONE   = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [AHB_ADDR_WIDTH-1:0]   r_addr;
  logic                        r_write;
  logic [2:0]                  r_size;
  logic [3:0]                  r_prot;
  logic [AHB_DATA_WIDTH-1:0]   r_rdata;

  logic w_accept;
  logic w_size_bad;
  logic w_misaligned;
  logic w_access;
  logic w_wr_access;
  logic w_load_rdata;
  logic w_timeout;
  logic w_unused_burst;

  assign w_unused_burst = ^ahb_burst_in;

  assign w_access     = (r_state == S_ACCESS);
  assign w_wr_access  = w_access && r_write;
  assign w_size_bad   = ((32'd8 << ahb_size_in) > 32'(AHB_DATA_WIDTH));
  assign w_misaligned = |(ahb_addr_in & ~({AHB_ADDR_WIDTH{1'b1}} << ahb_size_in));
  // New address phases are only taken while the previous data phase is completing.
  assign w_accept     = ahb_sel_in && ahb_ready_in && ahb_trans_in[1] &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2));
  assign w_load_rdata = w_access && other_ready_in && !other_error_in && !r_write;

`ifdef AHB_SLAVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (w_access && !other_ready_in) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = w_access && !other_ready_in &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept) begin
          w_state_next = (w_size_bad || w_misaligned) ? S_ERR1 : S_ACCESS;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (other_ready_in) begin
          w_state_next = other_error_in ? S_ERR1 : S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_ERR1;
        end
      end
      S_ERR1:  w_state_next = S_ERR2;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_prot  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= ahb_addr_in;
        r_write <= ahb_write_in;
        r_size  <= ahb_size_in;
        r_prot  <= ahb_prot_in;
      end
      // Read data lives for the DONE cycle only, then returns to zero.
      r_rdata <= w_load_rdata ? other_rdata_in : '0;
    end
  end

  assign ahb_readyout_out = !((r_state == S_ACCESS) || (r_state == S_ERR1));
  assign ahb_resp_out     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign ahb_rdata_out    = r_rdata;
  assign other_valid_out  = w_access;
  assign other_write_out  = r_write;
  assign other_addr_out   = r_addr;
  assign other_size_out   = r_size;
  assign other_prot_out   = r_prot;
  assign other_wdata_out  = w_wr_access ? ahb_wdata_in : '0;
  assign other_strb_out   = w_wr_access ? ahb_strb_in : '0;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: acts as AHB master and as a memory-backed backend, checked
// against a word-array reference memory and legality rules computed from size/address.
module tb_ahb_slave_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic          clk;
  logic          rstn;
  logic          sel;
  logic [AW-1:0] addr;
  logic [1:0]    trans;
  logic          write;
  logic [2:0]    size;
  logic [2:0]    burst;
  logic [3:0]    prot;
  logic [3:0]    strb;
  logic [DW-1:0] wdata;
  logic          readyout;
  logic          resp;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          o_write;
  logic [AW-1:0] o_addr;
  logic [2:0]    o_size;
  logic [3:0]    o_prot;
  logic [3:0]    o_strb;
  logic [DW-1:0] o_wdata;
  logic          b_ready;
  logic          b_err;
  logic [DW-1:0] b_rdata;

  logic [31:0] ref_mem [16];
  logic [31:0] bmem [16];
  int n_checks = 0;
  int n_fail = 0;

  ahb_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ahb_clk_in(clk), .ahb_rstn_in(rstn), .ahb_sel_in(sel), .ahb_addr_in(addr),
    .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size), .ahb_burst_in(burst),
    .ahb_prot_in(prot), .ahb_strb_in(strb), .ahb_wdata_in(wdata), .ahb_ready_in(readyout),
    .ahb_readyout_out(readyout), .ahb_resp_out(resp), .ahb_rdata_out(rdata),
    .other_valid_out(valid), .other_write_out(o_write), .other_addr_out(o_addr),
    .other_size_out(o_size), .other_prot_out(o_prot), .other_strb_out(o_strb),
    .other_wdata_out(o_wdata), .other_ready_in(b_ready), .other_error_in(b_err),
    .other_rdata_in(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bdef(input int i);
    return {16'hC0DE ^ 16'(i * 4), 16'h5A00 + 16'(i)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the slave can take an address phase; returns in the
  // completing data-phase cycle (DONE or ERR2) so the next address can follow at once.
  task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [1:0] tr, input logic [31:0] wd, input int lat,
                      input logic berr);
    logic       legal;
    logic [3:0] sb;
    logic [3:0] p;
    int         idx;
    legal = ((8 << sz) <= DW) && ((a % (32'd1 << sz)) == 0);
    sb    = legal ? 4'(((1 << (1 << sz)) - 1) << a[1:0]) : 4'h0;
    p     = 4'($urandom);
    idx   = int'(a[5:2]);
    sel = 1'b1; trans = tr; addr = a; write = wr; size = sz; prot = p;
    @(negedge clk);
    trans = T_IDLE; addr = '0; wdata = wd; strb = sb;
    #1;
    if (!legal) begin
      check("err1_valid", valid, 1'b0);
      check("err1_readyout", readyout, 1'b0);
      check("err1_resp", resp, 1'b1);
      @(negedge clk); #1;
      check("err2_readyout", readyout, 1'b1);
      check("err2_resp", resp, 1'b1);
      check("err2_valid", valid, 1'b0);
      $display("xfer %s a=%h sz=%0d -> illegal, ERROR response", wr ? "WR" : "RD", a, sz);
      return;
    end
    for (int j = 1; j <= lat; j++) begin
      if (j > 1) begin
        @(negedge clk); #1;
      end
      check("acc_valid", valid, 1'b1);
      check("acc_readyout", readyout, 1'b0);
      check("acc_resp", resp, 1'b0);
      check("acc_addr", o_addr, a);
      check("acc_write", o_write, wr);
      check("acc_size", o_size, sz);
      check("acc_prot", o_prot, p);
      check("acc_wdata", o_wdata, wr ? wd : 32'h0);
      check("acc_strb", o_strb, wr ? sb : 4'h0);
      if (j == lat) begin
        b_ready = 1'b1;
        b_err   = berr;
        b_rdata = bmem[o_addr[5:2]];
        if (o_write && !berr) begin
          for (int b = 0; b < 4; b++)
            if (o_strb[b]) bmem[o_addr[5:2]][8*b +: 8] = o_wdata[8*b +: 8];
        end
      end
    end
    @(negedge clk);
    b_ready = 1'b0; b_err = 1'b0; b_rdata = $urandom;
    #1;
    if (berr) begin
      check("berr1_readyout", readyout, 1'b0);
      check("berr1_resp", resp, 1'b1);
      check("berr1_valid", valid, 1'b0);
      @(negedge clk); #1;
      check("berr2_readyout", readyout, 1'b1);
      check("berr2_resp", resp, 1'b1);
      $display("xfer %s a=%h sz=%0d lat=%0d -> backend error", wr ? "WR" : "RD", a, sz, lat);
    end else begin
      check("done_readyout", readyout, 1'b1);
      check("done_resp", resp, 1'b0);
      check("done_valid", valid, 1'b0);
      check("done_rdata", rdata, wr ? 32'h0 : ref_mem[idx]);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (sb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      $display("xfer %s a=%h sz=%0d lat=%0d data=%h -> OKAY", wr ? "WR" : "RD", a, sz, lat,
               wr ? wd : ref_mem[idx]);
    end
  endtask

  task automatic idle_cycle(input logic s, input logic [1:0] tr);
    sel = s; trans = tr; addr = 32'($urandom_range(0, 63)); write = 1'($urandom); size = 3'd2;
    @(negedge clk);
    sel = 1'b1; trans = T_IDLE;
    #1;
    check("idle_readyout", readyout, 1'b1);
    check("idle_resp", resp, 1'b0);
    check("idle_valid", valid, 1'b0);
    check("idle_rdata", rdata, 32'h0);
    $display("idle sel=%0d trans=%0d -> OKAY, no request", s, tr);
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; sel = 1'b0; addr = '0; trans = T_IDLE; write = 1'b0; size = '0;
    burst = '0; prot = '0; strb = '0; wdata = '0; b_ready = 1'b0; b_err = 1'b0; b_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = bdef(i);
      bmem[i]    = bdef(i);
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_readyout", readyout, 1'b1);
    check("rst_resp", resp, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_write", o_write, 1'b0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_size", o_size, 3'h0);
    check("rst_prot", o_prot, 4'h0);
    check("rst_strb", o_strb, 4'h0);
    check("rst_wdata", o_wdata, 32'h0);
    $display("reset -> outputs at reset values");
    rstn = 1'b1;

    // Single write, then an INCR4 read with two-cycle backend latency.
    xfer(32'h10, 3'd2, 1'b1, T_NSEQ, 32'hA5A5_0001, 1, 1'b0);
    burst = 3'b011;
    for (int i = 0; i < 4; i++)
      xfer(32'h20 + 32'(4 * i), 3'd2, 1'b0, (i == 0) ? T_NSEQ : T_SEQ, 32'h0, 2, 1'b0);
    idle_cycle(1'b1, T_IDLE);
    xfer(32'h10, 3'd2, 1'b0, T_NSEQ, 32'h0, 1, 1'b0);

    // Oversize and misaligned transfers.
    burst = 3'b000;
    xfer(32'h10, 3'd3, 1'b0, T_NSEQ, 32'h0, 1, 1'b0);
    xfer(32'h22, 3'd2, 1'b1, T_NSEQ, 32'h1234_5678, 1, 1'b0);
    idle_cycle(1'b1, T_IDLE);

    // Backend error on beat two of INCR4; master abandons the burst in ERR2.
    burst = 3'b011;
    xfer(32'h30, 3'd2, 1'b0, T_NSEQ, 32'h0, 1, 1'b0);
    xfer(32'h34, 3'd2, 1'b0, T_SEQ, 32'h0, 1, 1'b1);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1, T_IDLE);

    burst = 3'b001;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       idle_cycle(1'b1, T_IDLE);
          1:       idle_cycle(1'b1, T_BUSY);
          default: idle_cycle(1'b0, T_NSEQ);
        endcase
      end else begin
        xfer(32'($urandom_range(0, 63)), 3'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(0, 1) ? T_SEQ : T_NSEQ, $urandom, $urandom_range(1, 4),
             ($urandom_range(0, 7) == 0));
      end
    end
    idle_cycle(1'b1, T_IDLE);

    // Reset asserted while a request is pending.
    sel = 1'b1; trans = T_NSEQ; addr = 32'h14; write = 1'b0; size = 3'd2;
    @(negedge clk);
    trans = T_IDLE;
    #1;
    check("rstacc_pre_valid", valid, 1'b1);
    rstn = 1'b0;
    @(negedge clk); #1;
    check("rstacc_readyout", readyout, 1'b1);
    check("rstacc_valid", valid, 1'b0);
    check("rstacc_rdata", rdata, 32'h0);
    check("rstacc_resp", resp, 1'b0);
    rstn = 1'b1;
    @(negedge clk); #1;
    check("rstacc_post_valid", valid, 1'b0);
    check("rstacc_post_readyout", readyout, 1'b1);
    $display("reset during ACCESS -> request dropped");

`ifdef AHB_SLAVE_TIMEOUT_EN
    sel = 1'b1; trans = T_NSEQ; addr = 32'h30; write = 1'b0; size = 3'd2;
    @(negedge clk);
    trans = T_IDLE;
    #1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!valid) break;
      cnt++;
      @(negedge clk); #1;
    end
    check("to_access_cycles", 32'(cnt), 32'(TO));
    check("to_err1_readyout", readyout, 1'b0);
    check("to_err1_resp", resp, 1'b1);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    #1;
    check("to_err2_readyout", readyout, 1'b1);
    check("to_err2_resp", resp, 1'b1);
    check("to_err2_valid", valid, 1'b0);
    @(negedge clk); #1;
    check("to_idle_valid", valid, 1'b0);
    check("to_idle_resp", resp, 1'b0);
    $display("timeout read a=00000030 -> ERROR after %0d ACCESS cycles", cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
